i2c_cmd_arbiter: RTL and testbench
==================================

# i2c_cmd_arbiter

Shares one `i2c_master_byte_ctrl` command port between N requesters, for example the touch-panel reader and a panel/EEPROM configuration engine on the MTL2 I2C bus. A requester locks the bus by issuing a START command. It keeps ownership until its STOP command completes or arbitration is lost. The arbiter uses round-robin fairness and runs a watchdog that force-stops the bus if a locked owner stalls.

## Interface
Parameters:
- N, 2: number of requesters (2..4).
- TIMEOUT, 1023: idle cycles allowed for a locked owner before a forced STOP.
- TO_W, 10: watchdog counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- req_valid  in  N  per-requester command valid, held until its req_done
- req_cmd  in  5N  per-requester {sta,sto,rd,wr,ack}; slice i = [5i+4:5i]
- req_din  in  8N  per-requester transmit byte; slice i = [8i+7:8i]
- req_done  out  N  one-cycle completion pulse to the owner
- grant  out  N  one-hot current owner; 0 when unlocked
- rxd  out  8  byte read by the last completed command
- rx_ack  out  1  slave ACK bit (0=ACK) of the last completed command
- al  out  1  arbitration lost; valid with req_done
- timeout_o  out  1  one-cycle pulse when a forced STOP completes
- busy  out  1  lock held or forced STOP in progress
- bc_cmd  out  5  {sta,sto,rd,wr,ack} to the byte controller
- bc_din  out  8  transmit byte to the byte controller
- bc_done, bc_al, bc_ack_out  in  1  byte-controller cmd_ack, i2c_al, ack_out
- bc_dout  in  8  byte-controller received byte

## Operation
States: IDLE, ISSUE, RESP, GRANT, FSTOP.

- **IDLE**
  - Requester i is eligible only if req_valid[i]=1 and its sta bit is 1.
  - Among eligible requesters, pick the first found searching from last_owner+1 with wrap-around.
  - The winner's grant bit is set and its cmd/din are latched into bc_cmd/bc_din. Next state is ISSUE.
  - Requesters that are valid without sta are ignored and never completed while unlocked.
- **ISSUE**
  - Hold bc_cmd/bc_din constant until bc_done or bc_al.
  - In that cycle, capture bc_dout into rxd, bc_ack_out into rx_ack, and bc_al into al. Clear bc_cmd to 0. Next state is RESP.
- **RESP**
  - req_done[owner]=1 for exactly one cycle.
  - If the completed command had sto=1, or al=1: clear grant, set last_owner=owner, go to IDLE.
  - Otherwise go to GRANT.
- **GRANT**
  - Only the owner's req_valid is sampled; all other requesters wait.
  - On owner valid: latch cmd/din, clear the watchdog, go to ISSUE. A sta=1 command here is a repeated START.
  - With no owner valid, the watchdog increments each cycle. At count==TIMEOUT, go to FSTOP.
- **FSTOP**
  - Drive bc_cmd = sto only (5'b01000) until bc_done or bc_al.
  - Then pulse timeout_o, clear grant, set last_owner=owner, go to IDLE.
  - No req_done is issued.
- **Other rules**
  - rxd, rx_ack, and al hold their values until the next completion.
  - busy = (state != IDLE).
  - Undefined state encodings go to IDLE with all outputs cleared.
  - Reset mid-transaction drops the lock with no STOP issued. The byte controller shares rst_i, so it resets to an idle bus with it.

## Timing
- **Reset values:** grant=0, req_done=0, rxd=0, rx_ack=0, al=0, timeout_o=0, busy=0, bc_cmd=0, bc_din=0, last_owner=N-1 (requester 0 wins first), watchdog=0.
- **Latency:**
  - Valid with sta at edge k → bc_cmd valid from cycle k+1.
  - bc_done at cycle m → req_done at cycle m+1.
  - Next owner command in GRANT is accepted at m+2 at the earliest.
- **Handshake:**
  - The requester must change or drop req_valid in the cycle after req_done. It is not sampled during RESP.
  - bc_cmd always returns to 0 for at least one cycle between commands, which matches the byte controller clearing its command register.
- **Simultaneous events:**
  - bc_done and bc_al in the same cycle is treated as a loss (al=1), and the lock is released.
  - Owner valid arriving in the same cycle the watchdog reaches TIMEOUT: the command wins and the watchdog clears.

## Test plan
- Requester 0 issues sta+wr 0x70, wr 0x00, sta+wr 0x71, rd×2 (last with ack=1), then sto. Expected: six req_done[0] pulses; rxd matches the model bytes; grant=01 throughout; grant=00 after the sto RESP.
- Both requesters assert sta in the same cycle from reset. Expected: requester 0 is granted and requester 1 waits. After requester 0's sto, requester 1 is granted. After requester 1's sto, with both requesting again, requester 0 is granted.
- Requester 1 asserts valid without sta while unlocked. Expected: no bc_cmd activity, no req_done, grant stays 00 for 100 cycles.
- Owner stalls in GRANT with TIMEOUT=16. Expected: bc_cmd=5'b01000 at the 17th idle cycle; timeout_o pulses after bc_done; grant=0; busy=0.
- Model asserts bc_al during a write. Expected: req_done with al=1, grant cleared, next requester can win in the following IDLE.
- rst_i asserted while in ISSUE. Expected: all outputs 0 asynchronously; after release, the first sta request is granted normally.

Source files
------------

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin lock arbiter sharing one I2C byte-controller command port
// A START locks the bus to one requester until its STOP completes, arbitration is lost, or the watchdog forces a STOP.
module i2c_cmd_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_valid,
  input  logic [5*N-1:0] req_cmd,
  input  logic [8*N-1:0] req_din,
  output logic [N-1:0]   req_done,
  output logic [N-1:0]   grant,
  output logic [7:0]     rxd,
  output logic           rx_ack,
  output logic           al,
  output logic           timeout_o,
  output logic           busy,
  output logic [4:0]     bc_cmd,
  output logic [7:0]     bc_din,
  input  logic           bc_done,
  input  logic           bc_al,
  input  logic           bc_ack_out,
  input  logic [7:0]     bc_dout
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_GRANT = 3'd3;
  localparam logic [2:0] S_FSTOP = 3'd4;
  logic [2:0]      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d, win_oh, sel_oh;
  logic [1:0]      last_q, last_d, own_idx;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [7:0]      rxd_q, rxd_d, din_q, din_d, sel_din;
  logic [4:0]      cmd_q, cmd_d, sel_cmd;
  logic            sto_q, sto_d, ack_q, ack_d, al_q, al_d, to_q, to_d;
  logic            found, sel_valid, bc_end;
  // later (smaller k) hits overwrite earlier ones, so the first eligible after last_owner wins
  always_comb begin
    win_oh = '0;
    for (int k = N; k >= 1; k--)
      for (int i = 0; i < N; i++)
        if ((int'(last_q) + k) % N == i && req_valid[i] && req_cmd[5*i+4]) win_oh = N'(1) << i;
  end
  always_comb begin
    sel_oh  = state_q == S_IDLE ? win_oh : grant_q;
    sel_cmd = '0;
    sel_din = '0;
    own_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) begin
        sel_cmd |= req_cmd[5*i +: 5];
        sel_din |= req_din[8*i +: 8];
      end
      if (grant_q[i]) own_idx = 2'(i);
    end
  end
  assign found     = |win_oh;
  assign sel_valid = |(req_valid & sel_oh);
  assign bc_end    = bc_done | bc_al;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    rxd_d   = rxd_q;
    ack_d   = ack_q;
    al_d    = al_q;
    to_d    = 1'b0;
    cmd_d   = cmd_q;
    din_d   = din_q;
    sto_d   = sto_q;
    case (state_q)
      S_IDLE: if (found) begin
        grant_d = win_oh;
        cmd_d   = sel_cmd;
        din_d   = sel_din;
        sto_d   = sel_cmd[3];
        state_d = S_ISSUE;
      end
      S_ISSUE: if (bc_end) begin
        rxd_d   = bc_dout;
        ack_d   = bc_ack_out;
        al_d    = bc_al;
        cmd_d   = '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        wd_d    = '0;
        state_d = sto_q || al_q ? S_IDLE : S_GRANT;
        grant_d = sto_q || al_q ? '0 : grant_q;
        last_d  = sto_q || al_q ? own_idx : last_q;
      end
      S_GRANT: if (sel_valid) begin
        cmd_d   = sel_cmd;
        din_d   = sel_din;
        sto_d   = sel_cmd[3];
        wd_d    = '0;
        state_d = S_ISSUE;
      end else begin
        wd_d = wd_q + 1'b1;
        if (wd_q == TO_W'(TIMEOUT - 1)) begin
          cmd_d   = 5'b01000;
          state_d = S_FSTOP;
        end
      end
      S_FSTOP: if (bc_end) begin
        to_d    = 1'b1;
        grant_d = '0;
        last_d  = own_idx;
        cmd_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        wd_d    = '0;
        rxd_d   = '0;
        ack_d   = 1'b0;
        al_d    = 1'b0;
        cmd_d   = '0;
        din_d   = '0;
        sto_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= 2'(N - 1);
      wd_q    <= '0;
      rxd_q   <= '0;
      ack_q   <= 1'b0;
      al_q    <= 1'b0;
      to_q    <= 1'b0;
      cmd_q   <= '0;
      din_q   <= '0;
      sto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      rxd_q   <= rxd_d;
      ack_q   <= ack_d;
      al_q    <= al_d;
      to_q    <= to_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      sto_q   <= sto_d;
    end
  end
  assign grant     = grant_q;
  assign req_done  = state_q == S_RESP ? grant_q : '0;
  assign busy      = state_q != S_IDLE;
  assign rxd       = rxd_q;
  assign rx_ack    = ack_q;
  assign al        = al_q;
  assign timeout_o = to_q;
  assign bc_cmd    = cmd_q;
  assign bc_din    = din_q;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: scoreboard bench with a byte-controller model and a round-robin lock model
module tb_i2c_cmd_arbiter;
  localparam int N = 2;
  localparam logic [4:0] STA = 5'b10000, STO = 5'b01000, RD = 5'b00100, WR = 5'b00010, ACK = 5'b00001;
  logic clk = 1'b0, rst_i;
  logic [N-1:0] req_valid, req_done, grant, elig, elig_hist;
  logic [5*N-1:0] req_cmd;
  logic [8*N-1:0] req_din;
  logic [7:0] rxd, bc_din, bc_dout;
  logic [4:0] bc_cmd, prev_cmd;
  logic rx_ack, al, timeout_o, busy, bc_done, bc_al, bc_ack_out;
  logic req_v [N];
  logic [4:0] req_c [N];
  logic [7:0] req_d [N];
  typedef struct { int o; logic [7:0] dout; logic ack; logic al; logic rel; } rsp_t;
  rsp_t rq [$];
  int tests = 0, fails = 0, to_seen = 0, exp_to = 0;
  int done_cnt [N];
  int m_owner = -1, m_last = N - 1;
  logic exp_fstop = 1'b0, inj_al = 1'b0, rand_al = 1'b0, rst_mode = 1'b0;
  logic pend_chk = 1'b0;
  logic [N-1:0] pc_grant;

  i2c_cmd_arbiter #(.N(N), .TIMEOUT(16), .TO_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid(req_valid), .req_cmd(req_cmd), .req_din(req_din),
    .req_done(req_done), .grant(grant), .rxd(rxd), .rx_ack(rx_ack), .al(al), .timeout_o(timeout_o),
    .busy(busy), .bc_cmd(bc_cmd), .bc_din(bc_din), .bc_done(bc_done), .bc_al(bc_al),
    .bc_ack_out(bc_ack_out), .bc_dout(bc_dout));

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = req_v[i];
      req_cmd[5*i +: 5]  = req_c[i];
      req_din[8*i +: 8]  = req_d[i];
      elig[i]            = req_v[i] & req_c[i][4];
    end

  always @(negedge clk) elig_hist <= elig;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // requester: hold the command until its own completion pulse, then drop valid
  task automatic req(input int i, input logic [4:0] c, input logic [7:0] d, output logic got_al);
    int n = 0;
    req_v[i] = 1'b1;
    req_c[i] = c;
    req_d[i] = d;
    do begin
      @(negedge clk);
      n++;
    end while (!req_done[i] && n < 2000);
    if (!req_done[i]) chk("req_wait_expired", 32'(n), 32'(0));
    got_al = al;
    @(posedge clk);
    #1 req_v[i] = 1'b0;
  endtask

  task automatic chain(input int i, input int len);
    logic g;
    logic [4:0] c;
    int r;
    req(i, STA | WR, 8'($urandom), g);
    for (int k = 0; k < len && !g; k++) begin
      r = $urandom_range(0, 2);
      c = r == 0 ? WR : r == 1 ? (RD | 5'($urandom_range(0, 1))) : (STA | WR);
      req(i, c, 8'($urandom), g);
    end
    if (!g) req(i, STO | WR, 8'($urandom), g);
  endtask

  // byte-controller model plus lock ownership reference
  initial begin
    int o, dl;
    logic [4:0] c;
    logic [7:0] d;
    logic alv, ackv;
    logic [7:0] doutv;
    bc_done = 1'b0; bc_al = 1'b0; bc_ack_out = 1'b0; bc_dout = '0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        m_owner = -1;
        m_last  = N - 1;
      end else if (bc_cmd != 0 && prev_cmd == 0 && !rst_mode) begin
        c = bc_cmd;
        d = bc_din;
        if (exp_fstop) begin
          o = m_owner;
          chk("fstop_cmd", 32'(c), 32'(STO));
          chk("fstop_grant", 32'(grant), 32'(oh(o)));
        end else begin
          if (m_owner < 0) begin
            o = -1;
            for (int k = 1; k <= N; k++) if (o < 0 && elig_hist[(m_last + k) % N]) o = (m_last + k) % N;
            chk("rr_winner_exists", 32'(o >= 0), 32'(1));
            m_owner = o < 0 ? 0 : o;
          end
          o = m_owner;
          chk("grant", 32'(grant), 32'(oh(o)));
          chk("bc_cmd", 32'(c), 32'(req_c[o]));
          chk("bc_din", 32'(d), 32'(req_d[o]));
        end
        dl = $urandom_range(0, 3);
        repeat (dl) begin
          @(negedge clk);
          chk("cmd_hold", 32'({bc_cmd, bc_din}), 32'({c, d}));
        end
        alv   = inj_al || (rand_al && $urandom_range(0, 5) == 0);
        inj_al = 1'b0;
        doutv = 8'($urandom);
        ackv  = 1'($urandom);
        @(posedge clk);
        #1;
        bc_done = alv ? 1'($urandom) : 1'b1;
        bc_al = alv;
        bc_dout = doutv;
        bc_ack_out = ackv;
        if (!exp_fstop) rq.push_back('{o, doutv, ackv, alv, c[3] | alv});
        @(posedge clk);
        #1;
        bc_done = 1'b0;
        bc_al = 1'b0;
        @(negedge clk);
        chk("cmd_clear", 32'(bc_cmd), 32'(0));
        if (exp_fstop) begin
          chk("timeout_pulse", 32'(timeout_o), 32'(1));
          chk("fstop_release", 32'({grant, busy}), 32'(0));
          exp_to++;
          exp_fstop = 1'b0;
        end
        if (exp_fstop || c[3] || alv || c == STO) begin
          m_last  = o;
          m_owner = -1;
        end
      end
      prev_cmd = bc_cmd;
    end
  end

  // monitor: pops one expected response per completion pulse
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (pend_chk) begin
        chk("grant_after_resp", 32'(grant), 32'(pc_grant));
        pend_chk = 1'b0;
      end
      if (timeout_o) to_seen++;
      if (req_done != 0) begin
        if (rq.size() == 0) chk("unexpected_done", 32'(req_done), 32'(0));
        else begin
          r = rq.pop_front();
          chk("done_owner", 32'(req_done), 32'(oh(r.o)));
          chk("rxd", 32'(rxd), 32'(r.dout));
          chk("rx_ack", 32'(rx_ack), 32'(r.ack));
          chk("al", 32'(al), 32'(r.al));
          pend_chk = 1'b1;
          pc_grant = r.rel ? '0 : oh(r.o);
          done_cnt[r.o]++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic g0, g1, g;
    logic [31:0] act;
    int n, d0;
    rst_i = 1'b0;
    for (int i = 0; i < N; i++) begin req_v[i] = 1'b0; req_c[i] = '0; req_d[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_vals", 32'({grant, req_done, rxd, rx_ack, al, timeout_o, busy, bc_cmd, bc_din}), 32'(0));
    @(posedge clk);
    #1 rst_i = 1'b1;
    // simultaneous START from reset, then again after requester 1 finishes
    for (int rnd = 0; rnd < 2; rnd++)
      fork
        begin req(0, STA | WR, 8'h70, g0); req(0, STO, 8'h00, g0); end
        begin req(1, STA | WR, 8'h90, g1); req(1, STO, 8'h00, g1); end
      join
    // single-owner transaction with repeated start and reads
    d0 = done_cnt[0];
    req(0, STA | WR, 8'h70, g); req(0, WR, 8'h00, g); req(0, STA | WR, 8'h71, g);
    req(0, RD, 8'h00, g); req(0, RD | ACK, 8'h00, g); req(0, STO, 8'h00, g);
    chk("t1_done_count", 32'(done_cnt[0] - d0), 32'(6));
    // valid without START while unlocked is ignored
    act = '0;
    req_v[1] = 1'b1;
    req_c[1] = WR;
    repeat (100) begin
      @(negedge clk);
      act |= 32'({bc_cmd, req_done, grant, busy});
    end
    chk("no_sta_ignored", act, 32'(0));
    #1 req_v[1] = 1'b0;
    @(posedge clk);
    #1;
    // owner stalls: forced STOP on the 17th cycle after entering GRANT
    req(0, STA | WR, 8'h3c, g);
    exp_fstop = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bc_cmd != STO && n < 40);
    chk("wd_cycles", 32'(n), 32'(17));
    repeat (8) @(posedge clk);
    #1;
    // command arriving exactly when the watchdog expires wins
    req(0, STA | WR, 8'h11, g);
    repeat (15) @(posedge clk);
    #1 req(0, STO | WR, 8'h22, g);
    // arbitration loss releases the lock to the waiting requester
    inj_al = 1'b1;
    fork
      begin req(0, STA | WR, 8'h5a, g0); chk("al_reported", 32'(g0), 32'(1)); end
      begin repeat (2) @(posedge clk); #1 req(1, STA | WR, 8'h6b, g1); req(1, STO, 8'h00, g1); end
    join
    // asynchronous reset during ISSUE
    repeat (3) @(posedge clk);
    #1 rst_mode = 1'b1;
    req_v[0] = 1'b1;
    req_c[0] = STA | WR;
    req_d[0] = 8'h55;
    repeat (2) @(negedge clk);
    chk("rst_pre_issue", 32'(bc_cmd), 32'(STA | WR));
    #2 rst_i = 1'b0;
    #1 chk("rst_async", 32'({grant, req_done, rxd, rx_ack, al, timeout_o, busy, bc_cmd, bc_din}), 32'(0));
    req_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    rst_mode = 1'b0;
    chain(1, 2);
    // randomized contention with random arbitration loss
    rand_al = 1'b1;
    for (int it = 0; it < 15; it++) begin
      fork
        begin
          int w = $urandom_range(0, 3);
          if ($urandom_range(0, 3) != 0) begin
            if (w > 0) begin repeat (w) @(posedge clk); #1; end
            chain(0, $urandom_range(0, 3));
          end
        end
        begin
          int w = $urandom_range(0, 3);
          if ($urandom_range(0, 3) != 0) begin
            if (w > 0) begin repeat (w) @(posedge clk); #1; end
            chain(1, $urandom_range(0, 3));
          end
        end
      join
    end
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(rq.size()), 32'(0));
    chk("timeout_pulses", 32'(to_seen), 32'(exp_to));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
